arithm2_stream_ctrl: RTL and testbench

Stream-side controller for the fixed-latency `arithm2` datapath. It accepts operand beats on a valid/ready handshake and drives them into the free-running pipeline, which has no stall capability because the multiplier cores ignore `ce`. It tracks in-flight results with a tag shift register and captures each `Y` into an output FIFO that downstream drains with its own valid/ready handshake. Credit accounting guarantees the FIFO can never overflow, so the pipeline never needs back-pressure.

---
 rtl/arithm2_stream_ctrl_pkg.sv | 24 ++
 rtl/arithm2_stream_ctrl_if.sv | 46 ++++
 rtl/sync_fifo_fwft.sv | 54 +++++
 rtl/arithm2_stream_ctrl.sv | 72 +++++++
 tb/tb_arithm2_stream_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arithm2_stream_ctrl_pkg.sv
// rtl/arithm2_stream_ctrl_pkg.sv - shared widths and defaults for the arithm2 stream controller
package arithm2_stream_ctrl_pkg;

  localparam int A_W = 18;
  localparam int B_W = 8;
  localparam int C_W = 12;
  localparam int D_W = 8;
  localparam int E_W = 14;
  localparam int F_W = 19;
  localparam int Y_W = 37;

  localparam int LAT_DEFAULT   = 10;
  localparam int DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic [D_W-1:0] d;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
  } operands_t;

endpackage

// File: rtl/arithm2_stream_ctrl_if.sv
// rtl/arithm2_stream_ctrl_if.sv - operand stream, datapath and result stream signals
interface arithm2_stream_ctrl_if;
  import arithm2_stream_ctrl_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic [C_W-1:0] in_c;
  logic [D_W-1:0] in_d;
  logic [E_W-1:0] in_e;
  logic [F_W-1:0] in_f;

  logic           pipe_ce;
  logic [A_W-1:0] pipe_a;
  logic [B_W-1:0] pipe_b;
  logic [C_W-1:0] pipe_c;
  logic [D_W-1:0] pipe_d;
  logic [E_W-1:0] pipe_e;
  logic [F_W-1:0] pipe_f;
  logic [Y_W-1:0] pipe_y;

  logic           out_valid;
  logic           out_ready;
  logic [Y_W-1:0] out_y;

  // master: source, datapath and sink around the controller
  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_e, in_f,
    input  in_ready,
    input  pipe_ce, pipe_a, pipe_b, pipe_c, pipe_d, pipe_e, pipe_f,
    output pipe_y,
    input  out_valid, out_y,
    output out_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_e, in_f,
    output in_ready,
    output pipe_ce, pipe_a, pipe_b, pipe_c, pipe_d, pipe_e, pipe_f,
    input  pipe_y,
    output out_valid, out_y,
    input  out_ready
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with occupancy output
module sync_fifo_fwft #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0] occ
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_valid = (occ != '0);
  assign full     = (occ == OCC_W'(DEPTH));
  assign pop      = rd_en && rd_valid;
  // at full a write is only taken when the head leaves in the same cycle
  assign push     = wr_en && (!full || pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/arithm2_stream_ctrl.sv
// rtl/arithm2_stream_ctrl.sv - credit-based stream controller for the free-running arithm2 datapath
module arithm2_stream_ctrl
  import arithm2_stream_ctrl_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arithm2_stream_ctrl_if.slave bus
);

  localparam int IF_W  = $clog2(LAT + 2);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(LAT + DEPTH + 2);

  logic [LAT:0]       tag;
  logic [IF_W-1:0]    inflight;
  logic [OCC_W-1:0]   occ;
  logic [SUM_W-1:0]   credit_used;
  logic               accept;
  operands_t          ops;

  // every slot in flight already owns a FIFO entry, so the pipeline never overflows it
  assign credit_used  = SUM_W'(inflight) + SUM_W'(occ);
  assign bus.in_ready = rst_n && (credit_used < SUM_W'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.pipe_ce  = rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag      <= '0;
      inflight <= '0;
    end else begin
      tag <= {tag[LAT-1:0], accept};
      if (accept && !tag[LAT])      inflight <= inflight + IF_W'(1);
      else if (!accept && tag[LAT]) inflight <= inflight - IF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops <= '0;
    end else if (accept) begin
      ops <= '{a: bus.in_a, b: bus.in_b, c: bus.in_c,
               d: bus.in_d, e: bus.in_e, f: bus.in_f};
    end
  end

  assign bus.pipe_a = ops.a;
  assign bus.pipe_b = ops.b;
  assign bus.pipe_c = ops.c;
  assign bus.pipe_d = ops.d;
  assign bus.pipe_e = ops.e;
  assign bus.pipe_f = ops.f;

  sync_fifo_fwft #(
    .WIDTH (Y_W),
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (tag[LAT]),
    .wr_data  (bus.pipe_y),
    .rd_en    (bus.out_ready),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out_y),
    .occ      (occ)
  );

endmodule

// File: tb/tb_arithm2_stream_ctrl.sv
// tb/tb_arithm2_stream_ctrl.sv - randomized self-checking bench with arithm2 datapath and result model
module tb_arithm2_stream_ctrl;
  import arithm2_stream_ctrl_pkg::*;

  localparam int LAT   = 10;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [Y_W-1:0] exp_q [$];
  logic [Y_W-1:0] dp_stage [LAT];

  arithm2_stream_ctrl_if bus ();

  arithm2_stream_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [Y_W-1:0] arith(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                           input logic [C_W-1:0] c, input logic [D_W-1:0] d,
                                           input logic [E_W-1:0] e, input logic [F_W-1:0] f);
    longint unsigned t;
    t = (longint'(a) + 32 * longint'(b)) * longint'(c)
      + 2 * (longint'(d) + 8) * (longint'(e) + longint'(f) + 15);
    return t[Y_W-1:0];
  endfunction

  // free-running datapath of latency LAT, no stall and no reset
  always @(posedge clk) begin
    dp_stage[0] <= arith(bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d, bus.pipe_e, bus.pipe_f);
    for (int i = 1; i < LAT; i++) dp_stage[i] <= dp_stage[i-1];
  end
  assign bus.pipe_y = dp_stage[LAT-1];

  task automatic rand_operands();
    bus.in_a = A_W'($urandom);
    bus.in_b = B_W'($urandom);
    bus.in_c = C_W'($urandom);
    bus.in_d = D_W'($urandom);
    bus.in_e = E_W'($urandom);
    bus.in_f = F_W'($urandom);
  endtask

  // one clock: sample handshakes, record accepted beats, end on the next falling edge
  task automatic step(output bit acc, output bit pop, output logic [Y_W-1:0] y);
    #1;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
    y   = bus.out_y;
    if (acc) exp_q.push_back(arith(bus.in_a, bus.in_b, bus.in_c, bus.in_d, bus.in_e, bus.in_f));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.pipe_ce} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: in_ready/out_valid/pipe_ce=%b required 000",
               {bus.in_ready, bus.out_valid, bus.pipe_ce});
    end
    tests_run++;
    if (bus.out_y !== '0) begin
      tests_failed++;
      $display("FAIL reset_out_y: got %h required 0", bus.out_y);
    end
    tests_run++;
    if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d, bus.pipe_e, bus.pipe_f} !== '0) begin
      tests_failed++;
      $display("FAIL reset_pipe_ops: nonzero operands a=%h f=%h", bus.pipe_a, bus.pipe_f);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.pipe_ce !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b pipe_ce=%b required 1 1", bus.in_ready, bus.pipe_ce);
    end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    bit acc, pop;
    logic [Y_W-1:0] y;
    bus.in_a = 1; bus.in_b = 1; bus.in_c = 2; bus.in_d = 1; bus.in_e = 1; bus.in_f = 1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step(acc, pop, y);
    bus.in_valid = 1'b0;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("FAIL single_accept: beat not accepted");
    end
    repeat (LAT) step(acc, pop, y);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early: out_valid=%b after %0d edges, required 0", bus.out_valid, LAT);
    end
    step(acc, pop, y);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 37'd372) begin
      tests_failed++;
      $display("FAIL single_result: out_valid=%b out_y=%0d required 1 372", bus.out_valid, bus.out_y);
    end
    bus.out_ready = 1'b1;
    step(acc, pop, y);
    bus.out_ready = 1'b0;
    tests_run++;
    if (!pop || exp_q.size() != 1 || y !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL single_pop: pop=%b y=%0d queued=%0d", pop, y, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_fill_no_drain();
    bit acc, pop;
    logic [Y_W-1:0] y, e;
    int accepts = 0;
    int pops = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_operands();
      step(acc, pop, y);
      if (acc) accepts++;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (accepts != DEPTH) begin
      tests_failed++;
      $display("FAIL fill_accepts: got %0d required %0d", accepts, DEPTH);
    end
    tests_run++;
    if (bus.in_ready !== 1'b0 || int'(dut.occ) != DEPTH || int'(dut.inflight) != 0) begin
      tests_failed++;
      $display("FAIL fill_state: in_ready=%b occ=%0d inflight=%0d required 0 %0d 0",
               bus.in_ready, dut.occ, dut.inflight, DEPTH);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && pops < DEPTH; i++) begin
      step(acc, pop, y);
      if (pop) begin
        pops++;
        e = exp_q.pop_front();
        tests_run++;
        if (y !== e) begin
          tests_failed++;
          $display("FAIL fill_order: result %0d got %h required %h", pops, y, e);
        end
        if (pops == 1) begin
          tests_run++;
          if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_credit_return: in_ready=%b after first pop, required 1", bus.in_ready);
          end
        end
      end
    end
    tests_run++;
    if (pops != DEPTH || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_drain: pops=%0d out_valid=%b required %0d 0", pops, bus.out_valid, DEPTH);
    end
    exp_q.delete();
  endtask

  task automatic test_full_rate();
    bit acc, pop;
    logic [Y_W-1:0] y, e;
    bit want_valid;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 116; k++) begin
      bus.in_valid = (k < 100);
      rand_operands();
      if (k < 100) begin
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL rate_in_ready: dropped before beat %0d", k);
        end
      end
      want_valid = (k >= LAT + 2) && (k <= 100 + LAT + 1);
      tests_run++;
      if (bus.out_valid !== want_valid) begin
        tests_failed++;
        $display("FAIL rate_out_valid: cycle %0d got %b required %b", k, bus.out_valid, want_valid);
      end
      step(acc, pop, y);
      if (pop) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rate_pop: unexpected result %h", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            tests_failed++;
            $display("FAIL rate_data: cycle %0d got %h required %h", k, y, e);
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rate_lost: %0d results never delivered", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_pushpop_full();
    bit acc, pop;
    logic [Y_W-1:0] y, e;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_operands();
      step(acc, pop, y);
    end
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = (i < 60);
      bus.out_ready = (i < 60) ? i[0] : 1'b1;
      rand_operands();
      #1;
      tests_run++;
      if (dut.tag[LAT] && int'(dut.occ) == DEPTH && !(bus.out_valid && bus.out_ready)) begin
        tests_failed++;
        $display("FAIL pushpop_overflow: write while full at cycle %0d", i);
      end
      tests_run++;
      if (exp_q.size() > DEPTH) begin
        tests_failed++;
        $display("FAIL pushpop_credit: outstanding %0d exceeds %0d", exp_q.size(), DEPTH);
      end
      step(acc, pop, y);
      if (pop) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL pushpop_dup: unexpected result %h", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            tests_failed++;
            $display("FAIL pushpop_order: cycle %0d got %h required %h", i, y, e);
          end
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pushpop_lost: %0d results never delivered", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    bit acc, pop;
    logic [Y_W-1:0] y;
    int stale = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_operands(); step(acc, pop, y); end
    bus.in_valid = 1'b0;
    repeat (LAT + 1) step(acc, pop, y);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_operands(); step(acc, pop, y); end
    bus.in_valid = 1'b0;
    step(acc, pop, y);
    tests_run++;
    if (int'(dut.occ) != 3 || int'(dut.inflight) != 5) begin
      tests_failed++;
      $display("FAIL midflight_setup: occ=%0d inflight=%0d required 3 5", dut.occ, dut.inflight);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.pipe_ce} !== 3'b000 || bus.out_y !== '0 ||
        {bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d, bus.pipe_e, bus.pipe_f} !== '0) begin
      tests_failed++;
      $display("FAIL midflight_reset: in_ready=%b out_valid=%b pipe_ce=%b out_y=%h",
               bus.in_ready, bus.out_valid, bus.pipe_ce, bus.out_y);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midflight_release: in_ready=%b required 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(acc, pop, y);
      if (bus.out_valid !== 1'b0) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++;
      $display("FAIL midflight_stale: out_valid high in %0d of 20 cycles, required 0", stale);
    end
    bus.out_ready = 1'b0;
    rand_operands();
    bus.in_valid = 1'b1;
    step(acc, pop, y);
    bus.in_valid = 1'b0;
    repeat (LAT) step(acc, pop, y);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_early: out_valid=%b before +%0d", bus.out_valid, LAT + 1);
    end
    step(acc, pop, y);
    tests_run++;
    if (exp_q.size() != 1 || bus.out_valid !== 1'b1 || bus.out_y !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL midflight_result: out_valid=%b out_y=%h queued=%0d",
               bus.out_valid, bus.out_y, exp_q.size());
    end
    bus.out_ready = 1'b1;
    step(acc, pop, y);
    exp_q.delete();
  endtask

  task automatic test_random_throttle();
    bit acc, pop;
    logic [Y_W-1:0] y, e;
    for (int i = 0; i < 10040; i++) begin
      bus.in_valid = (i < 10000) ? 1'($urandom) : 1'b0;
      bus.out_ready = (i < 10000) ? 1'($urandom) : 1'b1;
      rand_operands();
      #1;
      tests_run++;
      if (exp_q.size() > DEPTH ||
          (dut.tag[LAT] && int'(dut.occ) == DEPTH && !(bus.out_valid && bus.out_ready))) begin
        tests_failed++;
        $display("FAIL random_credit: cycle %0d outstanding=%0d occ=%0d", i, exp_q.size(), dut.occ);
      end
      step(acc, pop, y);
      if (pop) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL random_dup: unexpected result %h at cycle %0d", y, i);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            tests_failed++;
            $display("FAIL random_data: cycle %0d got %h required %h", i, y, e);
          end
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_lost: %0d results left, out_valid=%b", exp_q.size(), bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    bus.in_d = '0; bus.in_e = '0; bus.in_f = '0;
    test_reset();
    test_single_beat();
    test_fill_no_drain();
    test_full_rate();
    test_pushpop_full();
    test_reset_midflight();
    test_random_throttle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
